// File: rtl/speedy_pkg.sv
// Speedy-6-192 constants, tables and wiring-only helper layers.
// Shared by the round datapath and the engine controller.
package speedy_pkg;

  localparam int BLK  = 192;
  localparam int CELL = 6;
  localparam int NROW = 32;
  localparam int RC_N = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } fsm_e;

  localparam logic [CELL-1:0] SBOX [64] = '{
    6'h08, 6'h00, 6'h09, 6'h03, 6'h38, 6'h10, 6'h29, 6'h13,
    6'h0C, 6'h0D, 6'h04, 6'h07, 6'h30, 6'h01, 6'h20, 6'h23,
    6'h1A, 6'h12, 6'h18, 6'h32, 6'h3E, 6'h16, 6'h2C, 6'h36,
    6'h1C, 6'h1D, 6'h14, 6'h37, 6'h34, 6'h05, 6'h24, 6'h27,
    6'h02, 6'h06, 6'h0B, 6'h0F, 6'h33, 6'h17, 6'h21, 6'h15,
    6'h0A, 6'h1B, 6'h0E, 6'h1F, 6'h31, 6'h11, 6'h25, 6'h35,
    6'h22, 6'h26, 6'h2A, 6'h2E, 6'h3A, 6'h1E, 6'h28, 6'h3C,
    6'h2B, 6'h3B, 6'h2F, 6'h3F, 6'h39, 6'h19, 6'h2D, 6'h3D
  };

  // Row rotations of the column mixing (identity term added separately).
  localparam int MC_ROT [6] = '{1, 5, 9, 15, 21, 26};

  localparam logic [BLK-1:0] RC [RC_N] = '{
    192'h243F6A88_85A308D3_13198A2E_03707344_A4093822_299F31D0,
    192'h082EFA98_EC4E6C89_452821E6_38D01377_BE5466CF_34E90C6C,
    192'hC0AC29B7_C97C50DD_3F84D5B5_B5470917_9216D5D9_8979FB1B,
    192'hD1310BA6_98DFB5AC_2FFD72DB_D01ADFB7_B8E1AFED_6A267E96,
    192'hBA7C9045_F12C7F99_24A19947_B3916CF7_0801F2E2_858EFC16,
    192'h636920D8_71574E69_A458FEA3_F4933D7E_0D95748F_728EB658,
    192'h718BCD58_82154AEE_7B54A41D_C25A59B5_9C30D539_2AF26013
  };

  function automatic logic [BLK-1:0] sbox_layer(
    input logic [BLK-1:0] s
  );
    logic [BLK-1:0] r;
    r = '0;
    for (int i = 0; i < NROW; i++) begin
      r[CELL*i +: CELL] = SBOX[s[CELL*i +: CELL]];
    end
    return r;
  endfunction

  // Bit j of row i comes from bit j of row (i+j) mod 32.
  function automatic logic [BLK-1:0] shift_columns(
    input logic [BLK-1:0] s
  );
    logic [BLK-1:0] r;
    r = '0;
    for (int i = 0; i < NROW; i++) begin
      for (int j = 0; j < CELL; j++) begin
        r[CELL*i+j] = s[CELL*((i+j)%NROW)+j];
      end
    end
    return r;
  endfunction

  function automatic logic [BLK-1:0] key_perm(
    input logic [BLK-1:0] k
  );
    logic [BLK-1:0] r;
    r = '0;
    for (int j = 0; j < BLK; j++) begin
      r[j] = k[(7*j+1)%BLK];
    end
    return r;
  endfunction

  // Out-of-table indices yield zero rather than an X select.
  function automatic logic [BLK-1:0] rc_at(
    input logic [2:0] idx
  );
    return (idx < 3'(RC_N)) ? RC[idx] : '0;
  endfunction

endpackage

// File: rtl/mc_ac_ak.sv
// Column mixing followed by the combined round-constant/key add.
// Ports: state_i (192), ac_ak_i (192) -> state_o (192); combinational.
module mc_ac_ak
  import speedy_pkg::*;
(
  input  logic [BLK-1:0] state_i,
  input  logic [BLK-1:0] ac_ak_i,
  output logic [BLK-1:0] state_o
);

  logic [BLK-1:0] mix;

  always_comb begin
    mix = '0;
    for (int i = 0; i < NROW; i++) begin
      for (int j = 0; j < CELL; j++) begin
        mix[CELL*i+j] = state_i[CELL*i+j];
        for (int a = 0; a < 6; a++) begin
          mix[CELL*i+j] ^=
            state_i[CELL*((i+MC_ROT[a])%NROW)+j];
        end
      end
    end
  end

  assign state_o = mix ^ ac_ak_i;

endmodule

// File: rtl/speedy_round.sv
// One full Speedy round, purely combinational.
// Ports: state_i, ac_ak_i (192), last_i -> state_o (192).
module speedy_round
  import speedy_pkg::*;
(
  input  logic [BLK-1:0] state_i,
  input  logic [BLK-1:0] ac_ak_i,
  input  logic           last_i,
  output logic [BLK-1:0] state_o
);

  logic [BLK-1:0] half;
  logic [BLK-1:0] shc;
  logic [BLK-1:0] mixed;

  assign half = sbox_layer(shift_columns(sbox_layer(state_i)));
  assign shc  = shift_columns(half);

  mc_ac_ak u_mix (
    .state_i (shc),
    .ac_ak_i (ac_ak_i),
    .state_o (mixed)
  );

  // Final round skips the second ShiftColumns and the mixing;
  // ac_ak_i then carries the bare round key.
  assign state_o = last_i ? (half ^ ac_ak_i) : mixed;

endmodule

// File: rtl/speedy_enc_ctrl.sv
// Iterative Speedy-6-192 engine: one round per clock, valid/ready I/O.
// Ports: clk, rst_n, in_valid/in_ready/pt_in/key_in, out_valid/out_ready/ct_out, busy.
module speedy_enc_ctrl
  import speedy_pkg::*;
#(
  parameter int ROUNDS = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BLK-1:0] pt_in,
  input  logic [BLK-1:0] key_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BLK-1:0] ct_out,
  output logic           busy
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS-1);

  fsm_e fsm_q, fsm_d;

  logic [BLK-1:0] state_q, state_d;
  logic [BLK-1:0] key_q, key_d;
  logic [BLK-1:0] ct_q, ct_d;
  logic [RW-1:0]  rnd_q, rnd_d;

  logic           last;
  logic [BLK-1:0] ac_ak;
  logic [BLK-1:0] rnd_out;

  assign last  = (rnd_q == LAST_RND);
  assign ac_ak = last ? key_q : (rc_at(3'(rnd_q)) ^ key_q);

  speedy_round u_round (
    .state_i (state_q),
    .ac_ak_i (ac_ak),
    .last_i  (last),
    .state_o (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE: if (in_valid) fsm_d = S_RUN;
      S_RUN:  if (last) fsm_d = S_HOLD;
      S_HOLD: if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    busy      = (fsm_q == S_RUN);
    out_valid = (fsm_q == S_HOLD);
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = pt_in ^ key_in;
          key_d   = key_perm(key_in);
          rnd_d   = '0;
        end
      end
      S_RUN: begin
        if (last) begin
          ct_d = rnd_out;
        end else begin
          state_d = rnd_out;
          key_d   = key_perm(key_q);
          rnd_d   = rnd_q + RW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
    end
  end

  assign ct_out = ct_q;

endmodule
